// File: rtl/time_threshold_setter_pkg.sv
// Shared constants and encodings for the standby time-setting path and the set-display.
package time_threshold_setter_pkg;

  localparam int unsigned FIELD_W = 6;

  typedef enum logic [2:0] {
    AdjIdle = 3'b000,
    AdjSec  = 3'b001,
    AdjMin  = 3'b010,
    AdjHour = 3'b011
  } adjust_state_e;

  localparam logic [FIELD_W-1:0] SEC_MAX    = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX    = 6'd59;
  localparam logic [FIELD_W-1:0] HOUR_RESET = 6'd1;

  localparam int unsigned DEF_HOUR_MAX       = 23;
  localparam int unsigned DEF_GESTURE_MIN    = 1;
  localparam int unsigned DEF_GESTURE_MAX    = 30;
  localparam int unsigned DEF_GESTURE_SEC    = 5;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 10;
  localparam int unsigned DEF_HOLD_TICKS     = 250;
  localparam int unsigned DEF_REPEAT_TICKS   = 50;

  // Increment/decrement with wrap between 0 and max_val.
  function automatic logic [FIELD_W-1:0] step_wrap(input logic [FIELD_W-1:0] val,
                                                   input logic [FIELD_W-1:0] max_val,
                                                   input logic               up);
    if (up) begin
      return (val >= max_val) ? '0 : val + 6'd1;
    end
    return (val == '0) ? max_val : val - 6'd1;
  endfunction

endpackage

// File: rtl/time_threshold_setter_button_debounce.sv
// Button debouncer: one pulse per stable press, optional auto-repeat while held.
module time_threshold_setter_button_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned HOLD_TICKS     = 250,
  parameter int unsigned REPEAT_TICKS   = 50,
  parameter bit          REPEAT_EN      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);

  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    hold_d   = '0;
    hold_inc = hold_q + 1'b1;
    pulse    = 1'b0;
    // The pulse fires in the cycle the input completes its stability window.
    if (raw != stable_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
        stable_d = raw;
        pulse    = raw;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    if (REPEAT_EN && stable_q && raw) begin
      hold_d = hold_inc;
      if (hold_inc == HW'(HOLD_TICKS)) begin
        pulse = 1'b1;
      end else if (hold_inc == HW'(HOLD_TICKS + REPEAT_TICKS)) begin
        pulse  = 1'b1;
        hold_d = HW'(HOLD_TICKS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      hold_q   <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/time_threshold_setter.sv
// Turns mode/inc/dec buttons into reminder thresholds, gesture timeout and adjust state.
module time_threshold_setter
  import time_threshold_setter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS  = DEF_DEBOUNCE_TICKS,
  parameter int unsigned HOLD_TICKS      = DEF_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS    = DEF_REPEAT_TICKS,
  parameter int unsigned HOUR_MAX        = DEF_HOUR_MAX,
  parameter int unsigned GESTURE_MIN     = DEF_GESTURE_MIN,
  parameter int unsigned GESTURE_MAX     = DEF_GESTURE_MAX,
  parameter int unsigned GESTURE_DEFAULT = DEF_GESTURE_SEC
) (
  input  logic         clk_500Hz,
  input  logic         rst,
  input  logic         btn_mode,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic         is_standby,
  input  logic         reminder_duration_set_switch,
  input  logic         gesture_time_set_switch,
  output logic [5:0]   hour_threshold,
  output logic [5:0]   min_threshold,
  output logic [5:0]   sec_threshold,
  output logic [5:0]   gesture_sec,
  output logic [2:0]   adjust_state,
  output logic         threshold_update
);

  logic mode_p, inc_p, dec_p;
  logic r_en, g_en, inc_only, dec_only, edit;

  adjust_state_e state_q, state_d;
  logic [5:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d, gest_q, gest_d;
  logic          update_q, update_d;

  time_threshold_setter_button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b0)
  ) u_db_mode (.clk(clk_500Hz), .rst(rst), .raw(btn_mode), .pulse(mode_p));

  time_threshold_setter_button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b1)
  ) u_db_inc (.clk(clk_500Hz), .rst(rst), .raw(btn_inc), .pulse(inc_p));

  time_threshold_setter_button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b1)
  ) u_db_dec (.clk(clk_500Hz), .rst(rst), .raw(btn_dec), .pulse(dec_p));

  assign r_en     = is_standby & reminder_duration_set_switch;
  assign g_en     = is_standby & gesture_time_set_switch & ~r_en;
  assign inc_only = inc_p & ~dec_p;
  assign dec_only = dec_p & ~inc_p;
  assign edit     = (inc_only | dec_only) & ~mode_p;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    gest_d  = gest_q;
    if (r_en) begin
      unique case (state_q)
        AdjIdle: state_d = AdjSec;
        AdjSec: begin
          if (mode_p) state_d = AdjMin;
          else if (edit) sec_d = step_wrap(sec_q, SEC_MAX, inc_only);
        end
        AdjMin: begin
          if (mode_p) state_d = AdjHour;
          else if (edit) min_d = step_wrap(min_q, MIN_MAX, inc_only);
        end
        AdjHour: begin
          if (mode_p) state_d = AdjSec;
          else if (edit) hour_d = step_wrap(hour_q, 6'(HOUR_MAX), inc_only);
        end
        default: state_d = AdjIdle;
      endcase
      // A zero-length reminder is never allowed; drop the edit entirely.
      if (hour_d == '0 && min_d == '0 && sec_d == '0) begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
      end
    end else begin
      state_d = AdjIdle;
      if (g_en && edit) begin
        if (inc_only && gest_q < 6'(GESTURE_MAX)) gest_d = gest_q + 6'd1;
        else if (dec_only && gest_q > 6'(GESTURE_MIN)) gest_d = gest_q - 6'd1;
      end
    end
    update_d = (hour_d != hour_q) | (min_d != min_q) | (sec_d != sec_q) | (gest_d != gest_q);
  end

  always_ff @(posedge clk_500Hz) begin
    if (rst) begin
      state_q  <= AdjIdle;
      hour_q   <= HOUR_RESET;
      min_q    <= '0;
      sec_q    <= '0;
      gest_q   <= 6'(GESTURE_DEFAULT);
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      gest_q   <= gest_d;
      update_q <= update_d;
    end
  end

  assign hour_threshold   = hour_q;
  assign min_threshold    = min_q;
  assign sec_threshold    = sec_q;
  assign gesture_sec      = gest_q;
  assign adjust_state     = state_q;
  assign threshold_update = update_q;

endmodule
